br_resolve_unit: RTL and testbench
==================================

Name: br_resolve_unit

Overview:
- Parametrised successor to the branch-target calculator in EX.
- Computes the branch target as PC + 1 + sign-extended offset and evaluates the 3-bit condition code against the flags.
- Keeps a direct-mapped table of 2-bit saturating direction counters, looked up from fetch and trained at resolve.
- Registers each result behind a valid/ready output stage and raises a redirect when the resolved direction differs from the prediction made at fetch.

Parameters:
- PC_W, 16, PC and target width.
- OFF_W, 9, branch offset width (instr[OFF_W-1:0]); must be ≤ 9.
- IDX_W, 4, counter-table index width; the table has 2^IDX_W entries indexed by pc[IDX_W-1:0].
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken).
- MISS_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard the output stage; blocks accept this cycle.
- lk_pc  in  PC_W  fetch lookup PC.
- lk_taken  out  1  combinational prediction: table[lk_pc idx][1].
- in_vld  in  1  resolve request valid.
- in_rdy  out  1  unit can accept a request.
- in_pc  in  PC_W  PC of the instruction.
- in_instr  in  16  instruction word.
- in_flags  in  3  {Z,V,N}.
- in_pred  in  1  prediction the fetch stage used.
- out_vld  out  1  result valid.
- out_rdy  in  1  consumer ready.
- out_br  out  1  instruction was a branch (opcode 4'b1100).
- out_taken  out  1  resolved direction.
- out_target  out  PC_W  PC + 1 + sext(offset).
- redirect  out  1  direction mispredicted.
- redirect_pc  out  PC_W  correct next PC.
- miss_cnt  out  MISS_W  saturating mispredict count.

Behaviour:
- Reset (async, rst_n=0):
  - out_vld, out_br, out_taken, redirect = 0.
  - out_target, redirect_pc, miss_cnt = 0.
  - All counters = CTR_INIT.
- Handshake:
  - in_rdy = !flush && (!out_vld || out_rdy).
  - Accept = in_vld && in_rdy.
  - Output fields hold stable while out_vld && !out_rdy.
  - Latency: 1 cycle (accept at edge N, out_vld high after edge N).
  - Full throughput when out_rdy stays high.
- Output stage:
  - On accept: load the stage and set out_vld=1.
  - Else if out_rdy: clear out_vld.
  - flush has priority: out_vld=0 next edge, no accept, no table update, miss_cnt unchanged.
- Arithmetic:
  - off = sign-extend in_instr[OFF_W-1:0] to PC_W.
  - target = in_pc + 1 + off, modulo 2^PC_W (wraps silently).
  - fall = in_pc + 1, modulo 2^PC_W.
- Condition (ccc = in_instr[11:9]):
  - 000 NE: !Z.
  - 001 EQ: Z.
  - 010 GT: !Z && !N.
  - 011 LT: N.
  - 100 GTE: Z || !N.
  - 101 LTE: N || Z.
  - 110 OVFL: V.
  - 111 UNCOND: 1.
- Branch (opcode 1100):
  - out_br=1, out_taken=cond.
  - Table entry at in_pc idx: +1 if taken, −1 if not, saturating at 0 and 3.
- Non-branch:
  - out_br=0, out_taken=0, out_target still computed.
  - No table update.
- Redirect:
  - redirect = (out_taken != in_pred).
  - redirect_pc = out_taken ? target : fall.
  - A non-branch with in_pred=1 redirects to fall.
- miss_cnt: increments on each accepted request with redirect=1 and saturates at all-ones.
- Same-cycle lookup and update of the same index: lk_taken returns the pre-update value (read-before-write).
- Reset mid-operation: immediate clear of all state; pending result lost.

Test Plan:
- Reset then lookup: lk_pc=0x0005 → lk_taken=0; out_vld=0; miss_cnt=0.
- Taken branch, predicted not-taken:
  - Stimulus: in_pc=0x0010, instr=0xC203 (EQ, +3), flags Z=1, in_pred=0, out_rdy=1.
  - Next cycle: out_taken=1, out_target=0x0014, redirect=1, redirect_pc=0x0014, miss_cnt=1.
  - Counter at idx 0 goes 01→10; lk_pc=0x0000 then gives lk_taken=1.
- Negative offset and wrap:
  - in_pc=0x0000, instr=0xCFFE (UNCOND, −2), in_pred=1 → out_target=0xFFFF, redirect=0.
  - in_pc=0xFFFF, instr=0xCE00 (UNCOND, +0) → out_target=0x0000 (wrap).
- Backpressure:
  - Accept, then hold out_rdy=0 for 3 cycles → in_rdy=0, outputs stable, second request not accepted.
  - Raise out_rdy → second request accepted the same cycle; its result appears next cycle.
- Saturation: 5 taken resolves at pc=0x0003 → counter stays 11; 5 not-taken → stays 00.
- Flush and non-branch:
  - flush with in_vld=1 → out_vld=0 next cycle, table and miss_cnt unchanged.
  - Non-branch instr=0x1234 with in_pred=1, pc=0x0020 → out_br=0, redirect=1, redirect_pc=0x0021.

Source files
------------

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: computes branch target and condition outcome, trains a
// direct-mapped table of 2-bit direction counters and reports mispredictions.
module br_resolve_unit #(
    parameter int         PC_W     = 16,
    parameter int         OFF_W    = 9,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         MISS_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              lk_taken,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [15:0]       in_instr,
    input  logic [2:0]        in_flags,
    input  logic              in_pred,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              out_br,
    output logic              out_taken,
    output logic [PC_W-1:0]   out_target,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [MISS_W-1:0] miss_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]        ctr_q [ENTRIES];
    logic              out_vld_q;
    logic              out_br_q;
    logic              out_taken_q;
    logic [PC_W-1:0]   out_target_q;
    logic              redirect_q;
    logic [PC_W-1:0]   redirect_pc_q;
    logic [MISS_W-1:0] miss_q;

    logic              accept;
    logic              is_br_d;
    logic              cond_d;
    logic              taken_d;
    logic [PC_W-1:0]   off_d;
    logic [PC_W-1:0]   target_d;
    logic [PC_W-1:0]   fall_d;
    logic              redir_d;
    logic [PC_W-1:0]   redir_pc_d;
    logic [IDX_W-1:0]  upd_idx;
    logic [1:0]        ctr_cur;
    logic [1:0]        ctr_d;
    logic              lk_pc_unused;

    assign lk_pc_unused = ^lk_pc[PC_W-1:IDX_W];

    // The lookup reads the registered table, so a same-cycle update of the
    // same entry is only visible from the next cycle on.
    assign lk_taken = ctr_q[lk_pc[IDX_W-1:0]][1];

    assign in_rdy = !flush && (!out_vld_q || out_rdy);
    assign accept = in_vld && in_rdy;

    assign is_br_d  = (in_instr[15:12] == 4'b1100);
    assign off_d    = {{(PC_W-OFF_W){in_instr[OFF_W-1]}}, in_instr[OFF_W-1:0]};
    assign fall_d   = in_pc + PC_W'(1);
    assign target_d = fall_d + off_d;

    // Flags arrive as {Z,V,N}.
    always_comb begin
        cond_d = 1'b0;
        case (in_instr[11:9])
            3'b000:  cond_d = !in_flags[2];
            3'b001:  cond_d = in_flags[2];
            3'b010:  cond_d = !in_flags[2] && !in_flags[0];
            3'b011:  cond_d = in_flags[0];
            3'b100:  cond_d = in_flags[2] || !in_flags[0];
            3'b101:  cond_d = in_flags[0] || in_flags[2];
            3'b110:  cond_d = in_flags[1];
            default: cond_d = 1'b1;
        endcase
    end

    assign taken_d    = is_br_d && cond_d;
    assign redir_d    = (taken_d != in_pred);
    assign redir_pc_d = taken_d ? target_d : fall_d;

    assign upd_idx = in_pc[IDX_W-1:0];
    assign ctr_cur = ctr_q[upd_idx];

    always_comb begin
        ctr_d = ctr_cur;
        if (taken_d) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
        end else if (accept && is_br_d) begin
            ctr_q[upd_idx] <= ctr_d;
        end
    end

    // Flush wins over both loading and draining the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q     <= 1'b0;
            out_br_q      <= 1'b0;
            out_taken_q   <= 1'b0;
            out_target_q  <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else if (flush) begin
            out_vld_q <= 1'b0;
        end else if (accept) begin
            out_vld_q     <= 1'b1;
            out_br_q      <= is_br_d;
            out_taken_q   <= taken_d;
            out_target_q  <= target_d;
            redirect_q    <= redir_d;
            redirect_pc_q <= redir_pc_d;
        end else if (out_rdy) begin
            out_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else if (accept && redir_d && (miss_q != {MISS_W{1'b1}})) begin
            miss_q <= miss_q + MISS_W'(1);
        end
    end

    assign out_vld     = out_vld_q;
    assign out_br      = out_br_q;
    assign out_taken   = out_taken_q;
    assign out_target  = out_target_q;
    assign redirect    = redirect_q && out_vld_q;
    assign redirect_pc = redirect_pc_q;
    assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Scoreboard bench for br_resolve_unit: a driver feeds directed and random
// requests into a behavioural model, a monitor checks each delivered result.
module tb_br_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [15:0] lk_pc;
    logic        lk_taken;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] in_pc;
    logic [15:0] in_instr;
    logic [2:0]  in_flags;
    logic        in_pred;
    logic        out_vld;
    logic        out_rdy;
    logic        out_br;
    logic        out_taken;
    logic [15:0] out_target;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] miss_cnt;

    typedef struct {
        logic        br;
        logic        taken;
        logic [15:0] target;
        logic        redir;
        logic [15:0] rpc;
        logic [15:0] miss;
    } exp_t;

    exp_t expQ[$];
    int   tbl[16];
    bit   modelVld;
    int   modelMiss;
    int   passCnt  = 0;
    int   totalCnt = 0;
    bit   monOn    = 1'b0;

    br_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .lk_pc(lk_pc), .lk_taken(lk_taken),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_pc(in_pc), .in_instr(in_instr),
        .in_flags(in_flags), .in_pred(in_pred),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_br(out_br),
        .out_taken(out_taken), .out_target(out_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Condition rules evaluated straight from the flag meanings.
    function automatic bit condHolds(input int ccc, input bit z, input bit v, input bit n);
        case (ccc)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || !n;
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // One cycle: drive at negedge, check handshake/lookup, then advance the model.
    task automatic applyStimulus(input bit vld, input int pc, input int instr, input int flags,
                                 input bit pred, input bit ordy, input bit fl, input int lkpc);
        bit   expRdy;
        bit   acc;
        int   off;
        int   tgt;
        int   fall;
        bit   isBr;
        bit   tk;
        exp_t e;
        @(negedge clk);
        in_vld   = vld;
        in_pc    = 16'(pc);
        in_instr = 16'(instr);
        in_flags = 3'(flags);
        in_pred  = pred;
        out_rdy  = ordy;
        flush    = fl;
        lk_pc    = 16'(lkpc);
        #1;
        expRdy = !fl && (!modelVld || ordy);
        checkOutput("out_vld", 32'(out_vld), 32'(modelVld));
        checkOutput("in_rdy", 32'(in_rdy), 32'(expRdy));
        checkOutput("lk_taken", 32'(lk_taken), 32'(tbl[lkpc % 16] >= 2));
        acc = vld && expRdy;
        if (acc) begin
            off = instr % 512;
            if (off >= 256) off -= 512;
            fall = (pc + 1) % 65536;
            tgt  = (pc + 1 + off + 65536) % 65536;
            isBr = ((instr / 4096) % 16) == 12;
            tk   = isBr && condHolds((instr / 512) % 8, flags[2], flags[1], flags[0]);
            if (isBr) begin
                if (tk) tbl[pc % 16] = (tbl[pc % 16] == 3) ? 3 : tbl[pc % 16] + 1;
                else    tbl[pc % 16] = (tbl[pc % 16] == 0) ? 0 : tbl[pc % 16] - 1;
            end
            if (tk != pred && modelMiss < 65535) modelMiss++;
            e.br = isBr; e.taken = tk; e.target = 16'(tgt);
            e.redir = (tk != pred); e.rpc = tk ? 16'(tgt) : 16'(fall);
            e.miss = 16'(modelMiss);
            expQ.push_back(e);
        end
        @(posedge clk);
        if (fl)        modelVld = 1'b0;
        else if (acc)  modelVld = 1'b1;
        else if (ordy) modelVld = 1'b0;
    endtask

    // Monitor: a result is consumed when valid meets ready; flush discards it.
    initial begin : monitor
        bit          hold = 1'b0;
        logic [50:0] snap = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (monOn) begin
                if (hold)
                    checkOutput("stable", 32'({out_br, out_taken, out_target, redirect, redirect_pc} != snap[34:0]), 32'(0));
                snap = 51'({out_br, out_taken, out_target, redirect, redirect_pc});
                hold = out_vld && !out_rdy && !flush;
                if (out_vld && (out_rdy || flush)) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_result", 32'(1), 32'(0));
                    end else begin
                        e = expQ.pop_front();
                        if (!flush) begin
                            checkOutput("out_br", 32'(out_br), 32'(e.br));
                            checkOutput("out_taken", 32'(out_taken), 32'(e.taken));
                            checkOutput("out_target", 32'(out_target), 32'(e.target));
                            checkOutput("redirect", 32'(redirect), 32'(e.redir));
                            checkOutput("redirect_pc", 32'(redirect_pc), 32'(e.rpc));
                            checkOutput("miss_cnt", 32'(miss_cnt), 32'(e.miss));
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        int instr;
        rst_n = 1'b0; flush = 1'b0; lk_pc = 16'h0005; in_vld = 1'b0; in_pc = '0;
        in_instr = '0; in_flags = '0; in_pred = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 16; i++) tbl[i] = 1;
        modelVld = 1'b0; modelMiss = 0;
        #12;
        checkOutput("reset_lk_taken", 32'(lk_taken), 32'(0));
        checkOutput("reset_out_vld", 32'(out_vld), 32'(0));
        checkOutput("reset_miss_cnt", 32'(miss_cnt), 32'(0));
        checkOutput("reset_redirect", 32'(redirect), 32'(0));
        rst_n = 1'b1;
        monOn = 1'b1;

        applyStimulus(1, 16'h0010, 16'hC203, 3'b100, 0, 1, 0, 16'h0000);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0000);
        applyStimulus(1, 16'h0000, 16'hCFFE, 0, 1, 1, 0, 16'h0000);
        applyStimulus(1, 16'hFFFF, 16'hCE00, 0, 1, 1, 0, 16'h000F);

        applyStimulus(1, 16'h0031, 16'hC001, 3'b000, 0, 0, 0, 16'h0031);
        for (int i = 0; i < 3; i++) applyStimulus(1, 16'h0042, 16'hC7F0, 3'b001, 1, 0, 0, 16'h0002);
        applyStimulus(1, 16'h0042, 16'hC7F0, 3'b001, 1, 1, 0, 16'h0002);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0002);

        for (int i = 0; i < 5; i++) applyStimulus(1, 16'h0003, 16'hCE01, 0, 1, 1, 0, 16'h0003);
        for (int i = 0; i < 5; i++) applyStimulus(1, 16'h0003, 16'hCC01, 0, 0, 1, 0, 16'h0003);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0003);

        applyStimulus(1, 16'h0005, 16'hCE01, 0, 0, 1, 1, 16'h0005);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0005);
        applyStimulus(1, 16'h0020, 16'h1234, 0, 1, 1, 0, 16'h0020);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0000);

        for (int i = 0; i < 600; i++) begin
            instr = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) != 0) instr = 16'hC000 | (instr & 16'h0FFF);
            applyStimulus(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)), instr,
                          int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 15) == 0),
                          int'($urandom_range(0, 65535)));
        end

        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("queue_drained", 32'(expQ.size()), 32'(0));
        $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
